// File: rtl/slave_port_scheduler.sv
// -----------------------------------------------------------------------------
// slave_port_scheduler
//
// Request scheduler for one slave port of the crossbar. Each master owns one
// request slot. The scheduler picks among pending slots round-robin, drives a
// single transaction at a time onto the slave handshake, and routes the
// slave's ack / read response back to the master that was granted.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   m_req         per-master single-cycle request pulse
//   m_cmd         per-master command (0 = read, 1 = write)
//   m_addr        per-master address, master i at [i*AW +: AW]
//   m_wdata       per-master write data, master i at [i*32 +: 32]
//   m_ack         per-master ack pulse
//   m_resp        per-master read-response pulse
//   m_rdata       per-master read data, master i at [i*32 +: 32]
//   s_req         slave request pulse
//   s_cmd         slave command
//   s_addr        slave address
//   s_wdata       slave write data
//   s_ack         slave ack
//   s_resp        slave read response
//   s_rdata       slave read data
//   grant_id      index of the master being (or last) served
//   busy          transaction in flight
//   err           timeout error pulse
//
// Build option
//   SLAVE_PORT_SCHED_TIMEOUT_EN  enables the watchdog: a transaction stuck in
//   WAIT_ACK / WAIT_RESP for TIMEOUT cycles completes with an error
//   (err pulse, read data 32'hDEAD_BEEF). Undefined: waits forever, err = 0.
// -----------------------------------------------------------------------------

// One master's request slot. Holds a single pending transaction.
module slave_port_slot #(
    parameter int AW = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          cmd,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          grant,
    output logic          pending,
    output logic          slot_cmd,
    output logic [AW-1:0] slot_addr,
    output logic [31:0]   slot_wdata
);

    logic          pending_q, pending_d;
    logic          cmd_q, cmd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          load;

    always_comb begin
        // Load when the slot is empty and not being bypass-granted, or when it
        // is full and being granted this cycle (the new request replaces the
        // one leaving). A request into an empty slot that is granted in the
        // same cycle goes straight to the slave and never occupies the slot.
        load      = req && (pending_q == grant);
        pending_d = pending_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if (grant) begin
            pending_d = 1'b0;
        end
        if (load) begin
            pending_d = 1'b1;
            cmd_d     = cmd;
            addr_d    = addr;
            wdata_d   = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            cmd_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign pending    = pending_q;
    assign slot_cmd   = cmd_q;
    assign slot_addr  = addr_q;
    assign slot_wdata = wdata_q;

endmodule

module slave_port_scheduler #(
    parameter int MASTERS = 4,
    parameter int AW      = 30,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MASTERS-1:0]         m_req,
    input  logic [MASTERS-1:0]         m_cmd,
    input  logic [MASTERS*AW-1:0]      m_addr,
    input  logic [MASTERS*32-1:0]      m_wdata,
    output logic [MASTERS-1:0]         m_ack,
    output logic [MASTERS-1:0]         m_resp,
    output logic [MASTERS*32-1:0]      m_rdata,
    output logic                       s_req,
    output logic                       s_cmd,
    output logic [AW-1:0]              s_addr,
    output logic [31:0]                s_wdata,
    input  logic                       s_ack,
    input  logic                       s_resp,
    input  logic [31:0]                s_rdata,
    output logic [$clog2(MASTERS)-1:0] grant_id,
    output logic                       busy,
    output logic                       err
);

    localparam int IW = $clog2(MASTERS);

    if (MASTERS < 2 || (MASTERS & (MASTERS - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("slave_port_scheduler: MASTERS must be a power of 2 >= 2, TIMEOUT >= 2");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic                        s_req_q, s_req_d;
    logic                        s_cmd_q, s_cmd_d;
    logic [AW-1:0]               s_addr_q, s_addr_d;
    logic [31:0]                 s_wdata_q, s_wdata_d;
    logic [IW-1:0]               grant_q, grant_d;
    logic [IW-1:0]               last_q, last_d;
    logic [MASTERS-1:0]          m_ack_q, m_ack_d;
    logic [MASTERS-1:0]          m_resp_q, m_resp_d;
    logic [MASTERS-1:0][31:0]    m_rdata_q, m_rdata_d;

`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        err_q, err_d;
`endif

    // Slot array
    logic [MASTERS-1:0]          pending;
    logic [MASTERS-1:0]          slot_cmd;
    logic [MASTERS-1:0][AW-1:0]  slot_addr;
    logic [MASTERS-1:0][31:0]    slot_wdata;
    logic [MASTERS-1:0]          slot_grant;

    for (genvar i = 0; i < MASTERS; i++) begin : g_slot
        slave_port_slot #(.AW(AW)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .req        (m_req[i]),
            .cmd        (m_cmd[i]),
            .addr       (m_addr[i*AW +: AW]),
            .wdata      (m_wdata[i*32 +: 32]),
            .grant      (slot_grant[i]),
            .pending    (pending[i]),
            .slot_cmd   (slot_cmd[i]),
            .slot_addr  (slot_addr[i]),
            .slot_wdata (slot_wdata[i])
        );
    end

    // Round-robin pick. A request arriving this cycle counts as pending so an
    // idle scheduler issues it on the very next edge.
    logic [MASTERS-1:0] eff_pend;
    logic               found;
    logic [IW-1:0]      g;
    logic [IW-1:0]      idx;
    logic               sel_cmd;
    logic [AW-1:0]      sel_addr;
    logic [31:0]        sel_wdata;

    assign eff_pend = pending | m_req;

    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = '0;
        // MASTERS is a power of 2, so the IW-bit add wraps modulo MASTERS.
        for (int k = 1; k <= MASTERS; k++) begin
            idx = last_q + k[IW-1:0];
            if (!found && eff_pend[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    always_comb begin
        // A latched slot takes precedence; otherwise the payload is this
        // cycle's request being bypassed straight through.
        if (pending[g]) begin
            sel_cmd   = slot_cmd[g];
            sel_addr  = slot_addr[g];
            sel_wdata = slot_wdata[g];
        end else begin
            sel_cmd   = m_cmd[g];
            sel_addr  = m_addr[g*AW +: AW];
            sel_wdata = m_wdata[g*32 +: 32];
        end
    end

    always_comb begin
        slot_grant = '0;
        if (state_q == IDLE && found) begin
            slot_grant[g] = 1'b1;
        end
    end

    // Next-state and outputs
    always_comb begin
        state_d   = state_q;
        s_req_d   = 1'b0;
        s_cmd_d   = s_cmd_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        grant_d   = grant_q;
        last_d    = last_q;
        m_ack_d   = '0;
        m_resp_d  = '0;
        m_rdata_d = m_rdata_q;
`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (found) begin
                    s_req_d  = 1'b1;
                    s_cmd_d  = sel_cmd;
                    s_addr_d = sel_addr;
                    if (sel_cmd) begin
                        s_wdata_d = sel_wdata;
                    end
                    grant_d  = g;
                    last_d   = g;
                    state_d  = WAIT_ACK;
`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end

            WAIT_ACK: begin
                // s_resp is deliberately not looked at here.
                if (s_ack) begin
                    m_ack_d[grant_q] = 1'b1;
                    state_d          = s_cmd_q ? IDLE : WAIT_RESP;
`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
                    cnt_d            = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d            = 1'b1;
                    m_ack_d[grant_q] = 1'b1;
                    if (!s_cmd_q) begin
                        m_resp_d[grant_q]  = 1'b1;
                        m_rdata_d[grant_q] = 32'hDEAD_BEEF;
                    end
                    state_d          = IDLE;
                end else begin
                    cnt_d            = cnt_q + CW'(1);
`endif
                end
            end

            WAIT_RESP: begin
                if (s_resp) begin
                    m_resp_d[grant_q]  = 1'b1;
                    m_rdata_d[grant_q] = s_rdata;
                    state_d            = IDLE;
`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d              = 1'b1;
                    m_resp_d[grant_q]  = 1'b1;
                    m_rdata_d[grant_q] = 32'hDEAD_BEEF;
                    state_d            = IDLE;
                end else begin
                    cnt_d              = cnt_q + CW'(1);
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s_req_q   <= 1'b0;
            s_cmd_q   <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            grant_q   <= '0;
            last_q    <= IW'(MASTERS - 1);
            m_ack_q   <= '0;
            m_resp_q  <= '0;
            m_rdata_q <= '0;
`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            s_req_q   <= s_req_d;
            s_cmd_q   <= s_cmd_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            m_ack_q   <= m_ack_d;
            m_resp_q  <= m_resp_d;
            m_rdata_q <= m_rdata_d;
`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign s_req    = s_req_q;
    assign s_cmd    = s_cmd_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign grant_id = grant_q;
    assign m_ack    = m_ack_q;
    assign m_resp   = m_resp_q;
    assign m_rdata  = m_rdata_q;
    assign busy     = (state_q != IDLE);
`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule
